// File: rtl/dram_weight_fetch_pkg.sv
// Shared definitions for the layer-weight DRAM read master.
// Holds the fetch FSM state encoding, default widths and the FIFO word-width helper.
package dram_weight_fetch_pkg;

    localparam int DEF_D_WIDTH    = 4;
    localparam int DEF_A_WIDTH    = 22;
    localparam int DEF_LEN_WIDTH  = 23;
    localparam int DEF_FIFO_DEPTH = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    // Buffer word = {last, [run], data}; run only travels with the selective stream.
    function automatic int fifo_word_width(input int d_width, input int len_width, input bit with_run);
        return d_width + 1 + (with_run ? len_width : 0);
    endfunction

endpackage

// File: rtl/dram_fetch_fifo.sv
// Synchronous first-word-fall-through FIFO used as the output buffer of the weight fetcher.
// Read data is zero while empty so downstream never sees stale words after a flush.
module dram_fetch_fifo #(
    parameter int WIDTH = 5,
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             empty,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [CW-1:0]    count_reg;
    logic             full;
    logic             push_ok;
    logic             pop_ok;

    assign empty   = (count_reg == '0);
    assign full    = (count_reg == CW'(DEPTH));
    // A push into a full buffer is fine when the head leaves on the same edge.
    assign push_ok = push && (!full || pop);
    assign pop_ok  = pop && !empty;
    assign count   = count_reg;
    assign rdata   = empty ? '0 : mem[rd_ptr_reg];

    // Storage write; contents are don't-care until pointed at, so no reset.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr_reg] <= wdata;
        end
    end

    // Pointer and occupancy bookkeeping; DEPTH is a power of two so pointers wrap naturally.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   count_reg <= count_reg + CW'(1);
                2'b01:   count_reg <= count_reg - CW'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/dram_weight_fetch.sv
// Read-side master for the layer weight DRAM: walks a contiguous address range, absorbs the
// one-cycle read latency and streams words to the MAC array over valid/ready.
// Optional selective (run-length) stream enabled by defining SEL_SKIP_EN.
module dram_weight_fetch
    import dram_weight_fetch_pkg::*;
#(
    parameter int D_WIDTH    = DEF_D_WIDTH,
    parameter int A_WIDTH    = DEF_A_WIDTH,
    parameter int LEN_WIDTH  = DEF_LEN_WIDTH,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [A_WIDTH-1:0]   base_addr,
    input  logic [LEN_WIDTH-1:0] len,
    output logic                 busy,
    output logic                 done,
    output logic                 rce,
    output logic [A_WIDTH-1:0]   ra,
    input  logic [D_WIDTH-1:0]   rq,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic [D_WIDTH-1:0]   m_data,
    output logic                 m_last
`ifdef SEL_SKIP_EN
    ,
    output logic [LEN_WIDTH-1:0] m_run
`endif
);

`ifdef SEL_SKIP_EN
    localparam bit WITH_RUN = 1'b1;
`else
    localparam bit WITH_RUN = 1'b0;
`endif
    localparam int FW    = fifo_word_width(D_WIDTH, LEN_WIDTH, WITH_RUN);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int OCC_W = CNT_W + 2;

    state_t               state_reg, state_next;
    logic [A_WIDTH-1:0]   base_reg, base_next;
    logic [LEN_WIDTH-1:0] len_reg, len_next;
    logic [LEN_WIDTH-1:0] idx_reg, idx_next;
    logic                 rce_reg, rce_next;
    logic [A_WIDTH-1:0]   ra_reg, ra_next;
    logic                 rce_last_reg, rce_last_next;
    logic                 rd_pend_reg;
    logic                 rd_last_reg;
    logic                 done_reg, done_next;

    logic                 fifo_push;
    logic [FW-1:0]        fifo_wdata;
    logic                 fifo_pop;
    logic [FW-1:0]        fifo_rdata;
    logic                 fifo_empty;
    logic [CNT_W-1:0]     fifo_count;

    logic                 pend_slot;
    logic [OCC_W-1:0]     occupancy;
    logic [OCC_W-1:0]     occ_limit;
    logic                 can_issue;
    logic                 issue_last;

    assign busy     = (state_reg != ST_IDLE);
    assign done     = done_reg;
    assign rce      = rce_reg;
    assign ra       = ra_reg;
    assign m_valid  = !fifo_empty;
    assign fifo_pop = m_valid && m_ready;

    // Credits: every word issued but not yet handed downstream owns a buffer slot, including the
    // read on the bus, the word on rq and (selective stream) the pending run. A pop on this edge
    // frees its slot immediately, which keeps 1 word/cycle with a 4-deep buffer.
    assign occupancy  = OCC_W'(fifo_count) + OCC_W'(rce_reg) + OCC_W'(rd_pend_reg) + OCC_W'(pend_slot);
    assign occ_limit  = OCC_W'(FIFO_DEPTH) + OCC_W'(fifo_pop);
    assign can_issue  = (occupancy < occ_limit);
    assign issue_last = (idx_reg == (len_reg - LEN_WIDTH'(1)));

    // Next-state, address issue and done generation.
    always_comb begin
        state_next    = state_reg;
        base_next     = base_reg;
        len_next      = len_reg;
        idx_next      = idx_reg;
        rce_next      = 1'b0;
        ra_next       = ra_reg;
        rce_last_next = 1'b0;
        done_next     = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    if (len != '0) begin
                        // The buffer is empty here, so the first read goes out with the accept.
                        base_next     = base_addr;
                        len_next      = len;
                        rce_next      = 1'b1;
                        ra_next       = base_addr;
                        idx_next      = LEN_WIDTH'(1);
                        rce_last_next = (len == LEN_WIDTH'(1));
                        state_next    = (len == LEN_WIDTH'(1)) ? ST_DRAIN : ST_FETCH;
                    end else begin
                        done_next = 1'b1;
                    end
                end
            end
            ST_FETCH: begin
                if (can_issue) begin
                    rce_next      = 1'b1;
                    ra_next       = base_reg + idx_reg[A_WIDTH-1:0];
                    idx_next      = idx_reg + LEN_WIDTH'(1);
                    rce_last_next = issue_last;
                    if (issue_last) begin
                        state_next = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (fifo_pop && m_last) begin
                    done_next  = 1'b1;
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Control registers; reset aborts the job and drops any read still in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= ST_IDLE;
            base_reg     <= '0;
            len_reg      <= '0;
            idx_reg      <= '0;
            rce_reg      <= 1'b0;
            ra_reg       <= '0;
            rce_last_reg <= 1'b0;
            rd_pend_reg  <= 1'b0;
            rd_last_reg  <= 1'b0;
            done_reg     <= 1'b0;
        end else begin
            state_reg    <= state_next;
            base_reg     <= base_next;
            len_reg      <= len_next;
            idx_reg      <= idx_next;
            rce_reg      <= rce_next;
            ra_reg       <= ra_next;
            rce_last_reg <= rce_last_next;
            rd_pend_reg  <= rce_reg;
            rd_last_reg  <= rce_last_reg;
            done_reg     <= done_next;
        end
    end

`ifdef SEL_SKIP_EN
    logic                 pend_valid_reg, pend_valid_next;
    logic [D_WIDTH-1:0]   pend_data_reg, pend_data_next;
    logic [LEN_WIDTH-1:0] pend_run_reg, pend_run_next;
    logic                 flush_reg, flush_next;

    assign pend_slot = pend_valid_reg;

    // Run-length stage: merge equal neighbours, push a run when the word changes, and
    // flush the final run with last set on the cycle after the final return.
    always_comb begin
        pend_valid_next = pend_valid_reg;
        pend_data_next  = pend_data_reg;
        pend_run_next   = pend_run_reg;
        flush_next      = 1'b0;
        fifo_push       = 1'b0;
        fifo_wdata      = '0;
        if (flush_reg) begin
            fifo_push       = 1'b1;
            fifo_wdata      = {1'b1, pend_run_reg, pend_data_reg};
            pend_valid_next = 1'b0;
            pend_run_next   = '0;
        end else if (rd_pend_reg) begin
            if (pend_valid_reg && (rq == pend_data_reg)) begin
                pend_run_next = pend_run_reg + LEN_WIDTH'(1);
            end else begin
                if (pend_valid_reg) begin
                    fifo_push  = 1'b1;
                    fifo_wdata = {1'b0, pend_run_reg, pend_data_reg};
                end
                pend_valid_next = 1'b1;
                pend_data_next  = rq;
                pend_run_next   = LEN_WIDTH'(1);
            end
            flush_next = rd_last_reg;
        end
    end

    // Pending-run registers; each job starts with the stage empty.
    always_ff @(posedge clk) begin
        if (rst) begin
            pend_valid_reg <= 1'b0;
            pend_data_reg  <= '0;
            pend_run_reg   <= '0;
            flush_reg      <= 1'b0;
        end else begin
            pend_valid_reg <= pend_valid_next;
            pend_data_reg  <= pend_data_next;
            pend_run_reg   <= pend_run_next;
            flush_reg      <= flush_next;
        end
    end

    assign m_data = fifo_rdata[D_WIDTH-1:0];
    assign m_run  = fifo_rdata[D_WIDTH +: LEN_WIDTH];
    assign m_last = fifo_rdata[FW-1];
`else
    assign pend_slot  = 1'b0;
    assign fifo_push  = rd_pend_reg;
    assign fifo_wdata = {rd_last_reg, rq};
    assign m_data     = fifo_rdata[D_WIDTH-1:0];
    assign m_last     = fifo_rdata[FW-1];
`endif

    dram_fetch_fifo #(
        .WIDTH (FW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .wdata (fifo_wdata),
        .pop   (fifo_pop),
        .rdata (fifo_rdata),
        .empty (fifo_empty),
        .count (fifo_count)
    );

endmodule
